// File: rtl/pisa_mem_pkg.sv
// pisa_mem_pkg: shared widths and types for the PISA data/frame RAM port B users
package pisa_mem_pkg;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int BE_W = 4;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VGA} owner_t;
  typedef enum logic {NORMAL, CPU_FORCE} arb_state_t;
endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: RD_LATENCY-deep shift register of read-owner tags
module rd_tag_pipe import pisa_mem_pkg::*; #(
  parameter int RD_LATENCY = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  owner_t tag_in,
  output owner_t tag_out
);
  owner_t stage [RD_LATENCY];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) stage[i] <= OWN_NONE;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < RD_LATENCY; i++) stage[i] <= stage[i-1];
    end
  end
  assign tag_out = stage[RD_LATENCY-1];
endmodule

// File: rtl/ram_port_b_arbiter.sv
// ram_port_b_arbiter: shares RAM port B between CPU and VGA, VGA priority with bounded CPU starvation
module ram_port_b_arbiter import pisa_mem_pkg::*; #(
  parameter int RD_LATENCY = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [BE_W-1:0]   cpu_be,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic [ADDR_W-1:0] address_b,
  output logic [BE_W-1:0]   byteena_b,
  output logic [DATA_W-1:0] data_b,
  output logic              wren_b,
  input  logic [DATA_W-1:0] q_b
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  arb_state_t state;
  logic [CW-1:0] starve_cnt, cnt_next;
  logic force_cpu;
  owner_t tag_in, tag_out;
  always_comb begin
    force_cpu = state == CPU_FORCE;
    cpu_gnt = !reset && cpu_req && (force_cpu || !vga_req);
    vga_gnt = !reset && vga_req && !(force_cpu && cpu_req);
    cnt_next = (!cpu_req || cpu_gnt) ? '0 : (starve_cnt == LIM) ? starve_cnt : starve_cnt + 1'b1;
    address_b = cpu_gnt ? cpu_addr : vga_gnt ? vga_addr : '0;
    byteena_b = cpu_gnt ? cpu_be : vga_gnt ? {BE_W{1'b1}} : '0;
    data_b = cpu_gnt ? cpu_wdata : '0;
    wren_b = cpu_gnt && cpu_we;
    tag_in = cpu_gnt ? (cpu_we ? OWN_NONE : OWN_CPU) : vga_gnt ? OWN_VGA : OWN_NONE;
  end
  // Force is entered on the edge where the denial streak reaches the limit, so the CPU wins the very next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= NORMAL;
      starve_cnt <= '0;
    end else begin
      state <= (!force_cpu && cnt_next == LIM) ? CPU_FORCE : NORMAL;
      starve_cnt <= cnt_next;
    end
  end
  rd_tag_pipe #(.RD_LATENCY(RD_LATENCY)) u_tags (
    .clk(clk),
    .reset(reset),
    .tag_in(tag_in),
    .tag_out(tag_out)
  );
  assign cpu_rvalid = !reset && tag_out == OWN_CPU;
  assign vga_rvalid = !reset && tag_out == OWN_VGA;
  assign cpu_rdata = q_b;
  assign vga_rdata = q_b;
endmodule

// File: tb/tb_ram_port_b_arbiter.sv
// tb_ram_port_b_arbiter: directed and random checks of the port B arbiter against a transaction-level model
module tb_ram_port_b_arbiter;
  import pisa_mem_pkg::*;
  logic clk = 0, reset = 1;
  logic cpu_req = 0, cpu_we = 0, vga_req = 0;
  logic [ADDR_W-1:0] cpu_addr = '0, vga_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [3:0] cpu_be = '0;
  logic cpu_gnt, cpu_rvalid, vga_gnt, vga_rvalid, wren_b;
  logic [DATA_W-1:0] cpu_rdata, vga_rdata, data_b;
  logic [ADDR_W-1:0] address_b;
  logic [3:0] byteena_b;
  logic [DATA_W-1:0] q_b = '0, r1 = '0;
  int total = 0, bad = 0;

  ram_port_b_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .address_b(address_b), .byteena_b(byteena_b), .data_b(data_b), .wren_b(wren_b), .q_b(q_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [ADDR_W-1:0] a);
    return 32'hC0DE0000 ^ {15'b0, a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // RAM port B: registered address and registered output, two cycles to q_b
  logic [31:0] mem [logic [ADDR_W-1:0]];
  function automatic logic [31:0] ram_rd(input logic [ADDR_W-1:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction
  always @(posedge clk) begin
    if (wren_b) mem[address_b] = merge(ram_rd(address_b), data_b, byteena_b);
    r1 <= ram_rd(address_b);
    q_b <= r1;
  end

  // Transaction model: shadow memory, pending-read queue, CPU denial streak
  typedef struct { int own; int due; logic [31:0] data; } rd_t;
  rd_t pend [$];
  logic [31:0] smem [logic [ADDR_W-1:0]];
  int cyc = 0, streak = 0;
  bit forced = 0;
  function automatic logic [31:0] sm_rd(input logic [ADDR_W-1:0] a);
    return smem.exists(a) ? smem[a] : init_val(a);
  endfunction

  always @(negedge clk) begin
    bit ec, ev, ecr, evr;
    cyc++;
    if (reset) begin
      chk("rst_cpu_gnt", cpu_gnt, 0);
      chk("rst_vga_gnt", vga_gnt, 0);
      chk("rst_cpu_rvalid", cpu_rvalid, 0);
      chk("rst_vga_rvalid", vga_rvalid, 0);
      pend.delete();
      streak = 0;
      forced = 0;
    end else begin
      ec = cpu_req && (forced || !vga_req);
      ev = vga_req && !ec;
      chk("cpu_gnt", cpu_gnt, ec);
      chk("vga_gnt", vga_gnt, ev);
      chk("wren_b", wren_b, ec && cpu_we);
      chk("address_b", address_b, ec ? cpu_addr : ev ? vga_addr : '0);
      chk("byteena_b", byteena_b, ec ? cpu_be : ev ? 4'hF : 4'h0);
      chk("data_b", data_b, ec ? cpu_wdata : '0);
      ecr = pend.size() > 0 && pend[0].due == cyc && pend[0].own == 1;
      evr = pend.size() > 0 && pend[0].due == cyc && pend[0].own == 2;
      chk("cpu_rvalid", cpu_rvalid, ecr);
      chk("vga_rvalid", vga_rvalid, evr);
      if (ecr) chk("cpu_rdata", cpu_rdata, pend[0].data);
      if (evr) chk("vga_rdata", vga_rdata, pend[0].data);
      if (ecr || evr) void'(pend.pop_front());
      if (ec && cpu_we) smem[cpu_addr] = merge(sm_rd(cpu_addr), cpu_wdata, cpu_be);
      if (ec && !cpu_we) pend.push_back('{1, cyc + 2, sm_rd(cpu_addr)});
      if (ev) pend.push_back('{2, cyc + 2, sm_rd(vga_addr)});
      streak = (cpu_req && !ec) ? (streak < 4 ? streak + 1 : 4) : 0;
      forced = !forced && streak == 4;
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit cg, vg;
    mem[17'h00010] = 32'hDEADBEEF; smem[17'h00010] = 32'hDEADBEEF;
    mem[17'h00020] = 32'hFFFFFFFF; smem[17'h00020] = 32'hFFFFFFFF;
    cpu_req = 1; vga_req = 1;
    repeat (3) begin adv(); chk("reset_no_gnt", {cpu_gnt, vga_gnt}, 0); end
    cpu_req = 0; vga_req = 0; reset = 0;
    adv();
    // CPU-only read
    cpu_req = 1; cpu_we = 0; cpu_addr = 17'h00010; cpu_be = 4'hF;
    #1; chk("t1_gnt", cpu_gnt, 1); chk("t1_addr", address_b, 17'h00010);
    adv(); cpu_req = 0;
    adv(); #1;
    chk("t1_rvalid", cpu_rvalid, 1); chk("t1_rdata", cpu_rdata, 32'hDEADBEEF); chk("t1_vga_rvalid", vga_rvalid, 0);
    adv();
    // CPU write then read of the same word
    cpu_req = 1; cpu_we = 1; cpu_addr = 17'h00020; cpu_wdata = 32'h12345678; cpu_be = 4'b0011;
    #1; chk("t2_wren", wren_b, 1); chk("t2_be", byteena_b, 4'b0011);
    adv(); cpu_we = 0; cpu_wdata = 0; cpu_be = 4'hF;
    #1; chk("t2_rd_gnt", cpu_gnt, 1); chk("t2_rd_wren", wren_b, 0);
    adv(); cpu_req = 0;
    adv(); #1;
    chk("t2_rvalid", cpu_rvalid, 1); chk("t2_rdata", cpu_rdata, 32'hFFFF5678);
    repeat (3) adv();
    // Contention: V V V V C repeating
    cpu_req = 1; cpu_addr = 17'h00005; vga_req = 1; vga_addr = 17'h00100;
    for (int k = 0; k < 15; k++) begin
      #1; chk("t3_pattern", {cpu_gnt, vga_gnt}, (k % 5 == 4) ? 2'b10 : 2'b01);
      adv();
    end
    cpu_req = 0; vga_req = 0;
    repeat (4) adv();
    // Streaming VGA
    for (int k = 0; k < 10; k++) begin
      vga_req = k < 8; vga_addr = 17'h01000 + 17'(k);
      #1;
      chk("t4_gnt", vga_gnt, k < 8);
      chk("t4_rvalid", vga_rvalid, k >= 2);
      if (k >= 2) chk("t4_rdata", vga_rdata, init_val(17'h01000 + 17'(k - 2)));
      adv();
    end
    vga_req = 0;
    repeat (3) adv();
    // CPU drops its request in the forced cycle
    cpu_req = 1; vga_req = 1;
    repeat (4) begin #1; chk("t5_starve", {cpu_gnt, vga_gnt}, 2'b01); adv(); end
    cpu_req = 0;
    #1; chk("t5_drop", {cpu_gnt, vga_gnt}, 2'b01);
    adv(); cpu_req = 1;
    for (int k = 0; k < 5; k++) begin
      #1; chk("t5_after", {cpu_gnt, vga_gnt}, k == 4 ? 2'b10 : 2'b01);
      adv();
    end
    cpu_req = 0; vga_req = 0;
    repeat (4) adv();
    // Reset while a VGA read is in flight
    vga_req = 1; vga_addr = 17'h00200;
    #1; chk("t6_gnt", vga_gnt, 1);
    adv(); reset = 1;
    #1; chk("t6_rst_gnt", {cpu_gnt, vga_gnt}, 0);
    adv(); reset = 0; vga_req = 0;
    #1; chk("t6_dropped", vga_rvalid, 0);
    adv(); vga_req = 1; vga_addr = 17'h00201;
    #1; chk("t6_first_gnt", vga_gnt, 1);
    adv(); vga_req = 0;
    #1; chk("t6_no_rv", vga_rvalid, 0);
    adv(); #1;
    chk("t6_rv", vga_rvalid, 1); chk("t6_rdata", vga_rdata, init_val(17'h00201));
    adv();
    // Random traffic with hold-until-grant requesters
    cg = 0; vg = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!cpu_req || cg) begin
        cpu_req = $urandom_range(0, 2) != 0; cpu_we = $urandom_range(0, 1) == 1;
        cpu_addr = 17'($urandom_range(0, 31)); cpu_wdata = $urandom; cpu_be = 4'($urandom_range(0, 15));
      end
      if (!vga_req || vg) begin
        vga_req = $urandom_range(0, 1) == 1; vga_addr = 17'($urandom_range(0, 31));
      end
      reset = $urandom_range(0, 199) == 0;
      #1; cg = cpu_gnt; vg = vga_gnt;
      adv();
    end
    reset = 0; cpu_req = 0; vga_req = 0;
    repeat (4) adv();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
